// File: rtl/ce_pll_gen_pkg.sv
// ce_pll_gen_pkg: shared types, constants and frequency-word helper for the clock-enable generator.
package ce_pll_gen_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, LOCKING, LOCKED} state_e;

    localparam int LOCK_W = 8;

    // Rounded f_out/f_clk * 2^width, for constants and benches only.
    function automatic logic [63:0] freq_word(input longint f_clk_hz, input longint f_out_hz, input int width);
        return 64'(((f_out_hz << width) + f_clk_hz / 2) / f_clk_hz);
    endfunction

endpackage

// File: rtl/ce_pll_chan.sv
// ce_pll_chan: one phase accumulator with load, increment and registered carry-out enable.
module ce_pll_chan #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         run,
    input  logic [W-1:0] phase,
    input  logic [W-1:0] freq,
    output logic         ce
);
    logic [W-1:0] acc_q, acc_d;
    logic         ce_q, ce_d;
    logic [W:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, freq};
        acc_d = load ? phase : run ? sum[W-1:0] : acc_q;
        ce_d  = run & sum[W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;
endmodule

// File: rtl/ce_pll_gen.sv
// ce_pll_gen: N-channel fractional clock-enable generator with runtime reload and lock indication.
module ce_pll_gen
    import ce_pll_gen_pkg::*;
#(
    parameter int CHANNELS    = 3,
    parameter int ACC_WIDTH   = 32,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [ACC_WIDTH-1:0]          cfg_freq,
    input  logic [CHANNELS*ACC_WIDTH-1:0] cfg_phase,
    output logic [CHANNELS-1:0]           ce,
    output logic                          locked
);
    logic [1:0]                    sync_q, sync_d;
    logic                          rst_n;
    state_e                        state_q, state_d;
    logic [ACC_WIDTH-1:0]          freq_q, freq_d;
    logic [CHANNELS*ACC_WIDTH-1:0] phase_q, phase_d;
    logic [LOCK_W-1:0]             cnt_q, cnt_d;
    logic                          hs, load, run, lock_hit;

    // Assert asynchronously, release two clocks later.
    assign rst_n    = sync_q[1];
    assign hs       = cfg_valid & cfg_ready;
    assign lock_hit = state_q == LOCKING && ce[0] && cnt_q == LOCK_W'(LOCK_CYCLES - 1);

    always_comb begin
        sync_d  = {sync_q[0], 1'b1};
        freq_d  = hs ? cfg_freq : freq_q;
        phase_d = hs ? cfg_phase : phase_q;
        cnt_d   = load ? '0 : (state_q == LOCKING && ce[0]) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= sync_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_q  <= '0;
            phase_q <= '0;
            cnt_q   <= '0;
        end else begin
            freq_q  <= freq_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q == IDLE ? (enable ? LOAD : IDLE) :
                  state_q == LOAD ? (enable ? LOCKING : IDLE) :
                  !enable         ? IDLE :
                  hs              ? LOAD :
                  lock_hit        ? LOCKED : state_q;
    end

    // A pending reload suppresses accumulation so LOAD always shows ce low.
    always_comb begin
        cfg_ready = state_q != LOAD;
        locked    = state_q == LOCKED;
        load      = state_q == LOAD;
        run       = (state_q == LOCKING || state_q == LOCKED) & enable & ~cfg_valid;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        ce_pll_chan #(.W(ACC_WIDTH)) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load),
            .run   (run),
            .phase (phase_q[i*ACC_WIDTH +: ACC_WIDTH]),
            .freq  (freq_q),
            .ce    (ce[i])
        );
    end
endmodule

// File: tb/tb_ce_pll_gen.sv
// tb_ce_pll_gen: scoreboard bench for ce_pll_gen against a cycle-count reference model.
module tb_ce_pll_gen;
    import ce_pll_gen_pkg::*;

    localparam int CH = 3;
    localparam int W  = 8;
    localparam int LC = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          enable = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [W-1:0]  cfg_freq = '0;
    logic [CH*W-1:0] cfg_phase = '0;
    logic [CH-1:0] ce;
    logic          locked;

    always #5 clk = ~clk;

    ce_pll_gen #(.CHANNELS(CH), .ACC_WIDTH(W), .LOCK_CYCLES(LC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_freq  (cfg_freq),
        .cfg_phase (cfg_phase),
        .ce        (ce),
        .locked    (locked)
    );

    typedef struct packed {
        logic [CH-1:0] ce;
        logic          locked;
        logic          rdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t me;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ce0_seen = 0;

    // Reference model: mode 0 idle, 1 load, 2 locking, 3 locked.
    // Pulse i occurs when phase + steps*freq crosses a multiple of 2^W.
    int     m_mode = 0;
    longint m_f = 0;
    longint m_ph[CH];
    longint m_steps = 0;
    int     m_pulses = 0;
    int     m_sync = 0;
    logic   m_ce0 = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [CH*W-1:0] ph3(input int a, input int b, input int c);
        return {W'(c), W'(b), W'(a)};
    endfunction

    task automatic step(input logic rn, input logic en, input logic v, input logic [W-1:0] f, input logic [CH*W-1:0] ph);
        exp_t          e;
        logic [CH-1:0] ce_n;
        int            nxt;
        logic          hs;
        @(negedge clk);
        reset_n = rn;
        enable = en;
        cfg_valid = v;
        cfg_freq = f;
        cfg_phase = ph;
        ce_n = '0;
        if (!rn) begin
            m_mode = 0;
            m_f = 0;
            for (int i = 0; i < CH; i++) m_ph[i] = 0;
            m_steps = 0;
            m_pulses = 0;
            m_sync = 0;
        end else if (m_sync < 2) begin
            m_sync++;
        end else begin
            hs = v && m_mode != 1;
            nxt = m_mode;
            case (m_mode)
                0: nxt = en ? 1 : 0;
                1: begin
                    m_steps = 0;
                    m_pulses = 0;
                    nxt = en ? 2 : 0;
                end
                default: begin
                    if (!en) nxt = 0;
                    else if (hs) nxt = 1;
                    else begin
                        for (int i = 0; i < CH; i++)
                            ce_n[i] = ((m_ph[i] + (m_steps + 1) * m_f) >> W) != ((m_ph[i] + m_steps * m_f) >> W);
                        m_steps++;
                        if (m_mode == 2 && m_ce0) begin
                            m_pulses++;
                            if (m_pulses == LC) nxt = 3;
                        end
                    end
                end
            endcase
            if (hs) begin
                m_f = longint'(f);
                for (int i = 0; i < CH; i++) m_ph[i] = longint'(ph[i*W +: W]);
            end
            m_mode = nxt;
        end
        m_ce0 = ce_n[0];
        e.ce = ce_n;
        e.locked = m_mode == 3;
        e.rdy = m_mode != 1;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            check("ce", longint'(ce), longint'(me.ce));
            check("locked", longint'(locked), longint'(me.locked));
            check("cfg_ready", longint'(cfg_ready), longint'(me.rdy));
        end
        if (ce[0]) ce0_seen++;
    end

    initial begin
        logic [W-1:0]    f;
        logic [CH*W-1:0] ph;
        int              c0;
        int              fw;
        logic            en, v, rn;
        for (int i = 0; i < CH; i++) m_ph[i] = 0;
        #3 reset_n = 1'b0;
        #1;
        check("reset_ce", longint'(ce), 0);
        check("reset_locked", longint'(locked), 0);
        check("reset_ready", longint'(cfg_ready), 1);
        repeat (3) step(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) step(1'b1, 1'b0, 1'b0, '0, '0);

        // Nominal: period 4, staggered first pulses, lock after 16 ce[0] pulses.
        ph = ph3(0, 128, 192);
        step(1'b1, 1'b1, 1'b1, 8'd64, ph);
        repeat (90) step(1'b1, 1'b1, 1'b0, 8'd64, ph);

        // Reload while locked: period becomes 8.
        step(1'b1, 1'b1, 1'b1, 8'd32, ph);
        repeat (160) step(1'b1, 1'b1, 1'b0, 8'd32, ph);

        // Disable during LOCKING, then reconfigure while disabled.
        step(1'b1, 1'b1, 1'b1, 8'd32, ph);
        repeat (20) step(1'b1, 1'b1, 1'b0, 8'd32, ph);
        step(1'b1, 1'b0, 1'b0, 8'd32, ph);
        step(1'b1, 1'b0, 1'b1, 8'd32, ph3(64, 0, 200));
        step(1'b1, 1'b0, 1'b0, 8'd99, ph3(1, 2, 3));
        repeat (40) step(1'b1, 1'b1, 1'b0, 8'd99, ph3(1, 2, 3));

        // Zero frequency never locks.
        step(1'b1, 1'b1, 1'b1, 8'd0, ph3(10, 20, 30));
        repeat (1000) step(1'b1, 1'b1, 1'b0, 8'd0, ph3(10, 20, 30));

        // Fractional rate from the helper; pulse density over a fixed window.
        check("freq_word32", longint'(freq_word(74250000, 13107200, 32)),
              longint'($floor(13107200.0 * 4294967296.0 / 74250000.0 + 0.5)));
        fw = int'(freq_word(74250000, 13107200, W));
        step(1'b1, 1'b1, 1'b1, W'(fw), ph3(0, 85, 170));
        repeat (100) step(1'b1, 1'b1, 1'b0, W'(fw), ph3(0, 85, 170));
        c0 = ce0_seen;
        repeat (2560) step(1'b1, 1'b1, 1'b0, W'(fw), ph3(0, 85, 170));
        n_cmp++;
        if ((ce0_seen - c0) - (2560 * fw) / 256 > 1 || (2560 * fw) / 256 - (ce0_seen - c0) > 1) begin
            n_bad++;
            $display("FAIL frac_count: got %0d expected %0d +-1", ce0_seen - c0, (2560 * fw) / 256);
        end

        // Near-continuous enables, then asynchronous reset mid-LOCKED.
        step(1'b1, 1'b1, 1'b1, 8'd255, ph3(0, 0, 0));
        repeat (40) step(1'b1, 1'b1, 1'b0, 8'd255, ph3(0, 0, 0));
        step(1'b0, 1'b1, 1'b0, 8'd255, ph3(0, 0, 0));
        #1;
        check("async_ce", longint'(ce), 0);
        check("async_locked", longint'(locked), 0);
        step(1'b0, 1'b1, 1'b0, 8'd255, ph3(0, 0, 0));
        repeat (30) step(1'b1, 1'b1, 1'b0, 8'd255, ph3(0, 0, 0));

        // Randomised traffic with occasional reloads, disables and resets.
        f = 8'd64;
        ph = ph3(0, 128, 192);
        repeat (3000) begin
            rn = $urandom_range(0, 499) != 0;
            en = $urandom_range(0, 19) != 0;
            v  = $urandom_range(0, 49) == 0;
            case ($urandom_range(0, 4))
                0: f = 8'd0;
                1: f = 8'd128;
                2: f = 8'd255;
                default: f = W'($urandom_range(1, 255));
            endcase
            ph = CH*W'($urandom);
            step(rn, en, v, f, ph);
        end
        step(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ce_pll_gen.md
# ce_pll_gen

Parametrised digital clock-enable generator: N-channel fractional (phase-accumulator) divider running from one fabric clock. Replaces fixed-frequency PLL outputs for slow core clocks (e.g. 13.1072 MHz from 74.25 MHz) with per-channel single-cycle enables. Each channel has a programmable phase offset. Frequency and phases are reloadable at runtime. A lock indication follows each (re)load. Sits between the top-level clock input and every core block that needs a derived-rate enable.

## Interface
- CHANNELS, 3, number of enable outputs (1..8)
- ACC_WIDTH, 32, accumulator / frequency-word width (8..32)
- LOCK_CYCLES, 16, channel-0 pulses required before `locked` asserts (1..255)

- clk  in  1  fabric clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run request; low stops generation
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  configuration accepted when both high
- cfg_freq  in  ACC_WIDTH  increment per clk; f_out = f_clk·cfg_freq/2^ACC_WIDTH
- cfg_phase  in  CHANNELS·ACC_WIDTH  channel i offset in bits [i·ACC_WIDTH +: ACC_WIDTH]
- ce  out  CHANNELS  single-cycle enable pulses
- locked  out  1  generation stable since last load

## Operation
- Reset values: ce=0, locked=0, cfg_ready=1, state IDLE, stored freq=0, stored phases=0, accumulators=0.
- Config registers capture cfg_freq/cfg_phase on every handshake (cfg_valid & cfg_ready), in any state except LOAD.
- Per channel: acc_i ← acc_i + freq (mod 2^ACC_WIDTH); ce_i ← carry-out of that add (registered).
- FSM states:
  - IDLE: no accumulation, ce=0, locked=0. Exits to LOAD when enable=1.
  - LOAD: one cycle. acc_i ← stored phase_i, lock counter ← 0, ce=0, locked=0, cfg_ready=0. Then goes to LOCKING, or IDLE if enable=0.
  - LOCKING: accumulate; count ce[0] pulses; goes to LOCKED on pulse number LOCK_CYCLES.
  - LOCKED: accumulate; locked=1.
- In LOCKING/LOCKED:
  - handshake → LOAD next cycle.
  - enable=0 → IDLE next cycle; ce and locked cleared that cycle.
- enable=0 in IDLE with handshake: config stored, state stays IDLE.
- Simultaneous enable rise and handshake in IDLE: LOAD uses the new config.
- freq=0: no pulses; FSM remains in LOCKING indefinitely, locked=0.
- freq ≥ 2^(ACC_WIDTH−1): legal; pulses at most every 2 cycles, and every cycle when freq wraps (freq=2^ACC_WIDTH−1 gives ce high continuously except periodic gaps).
- Phase semantics: larger phase → earlier first pulse; channels with equal phase pulse in the same cycle.

## Timing
- Handshake at cycle t → LOAD at t+1 → first accumulate at t+2. The first ce is possible at t+3, because ce is registered from the carry.
- Example, ACC_WIDTH=8, freq=64, phase=0: acc values 64,128,192,0 from t+2; ce at t+6, then every 4 cycles.
- locked rises the cycle after the LOCK_CYCLES-th ce[0] pulse. It falls in the cycle after an exit from LOCKED: LOAD, IDLE, or reset.
- cfg_ready is combinational from state only (low in LOAD), never from cfg_valid.
- reset_n asserted mid-operation: all outputs clear immediately (asynchronous). Release is synchronised internally with a 2-flop synchroniser; the first state change is no earlier than 2 cycles after release.

## Structure
- Package ce_pll_gen_pkg: state enum (IDLE, LOAD, LOCKING, LOCKED), lock-counter width constant, and a helper function that computes the frequency word from integer Hz values (for benches and top-level constants).
- Sub-module ce_pll_chan: one accumulator with load, increment and registered carry; instantiated CHANNELS times via generate.
- Top holds the FSM, config registers, lock counter and reset synchroniser.

## Test plan
- ACC_WIDTH=8, freq=64, phases {0,128,192}, enable=1: ce[0] every 4 cycles; first pulses ce[2] at t+3, ce[1] at t+4, ce[0] at t+6. locked after 16 ce[0] pulses.
- ACC_WIDTH=32, freq for 74.25→13.1072 MHz (≈758181755): over 742500 cycles, count of ce[0] = 131072 ±1.
- Reconfigure while LOCKED (freq 64→32): cfg_ready low exactly one cycle; locked drops next cycle; period becomes 8; locked regained after 16 pulses.
- enable low in LOCKING: ce=0 and locked=0 next cycle. Handshake while disabled then enable=1: LOAD uses the new phases.
- freq=0, enable=1 for 1000 cycles: no ce, locked=0, state LOCKING.
- reset_n pulsed low mid-LOCKED: ce, locked cleared asynchronously; no activity until 2 cycles after release; restart from IDLE with stored config = 0.
